// File: rtl/encoder_8b10b_lanes.sv
// Multi-lane 8b/10b encoder using the IEEE 802.3 Cl.36 5b/6b and 3b/4b code
// tables. It has one registered output stage behind a ready/valid handshake.
// Each lane keeps its own running disparity. A control request for a byte
// that is not a legal K code is flagged per lane. That byte is then either
// encoded as data or replaced by an all-zero word, as set by ERR_ZERO.
module encoder_8b10b_lanes #(
    parameter int LANES    = 2,
    parameter bit ERR_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic [8*LANES-1:0]    entradas,
    input  logic [LANES-1:0]      K,
    input  logic                  rdy,
    output logic                  listo,
    output logic [10*LANES-1:0]   salidas,
    output logic                  valido,
    output logic [LANES-1:0]      rd,
    output logic [LANES-1:0]      err_k
);

    localparam int BW = 8;
    localparam int CW = 10;

    // 5b/6b code (abcdei) as seen with RD- at the start of the sub-block.
    function automatic logic [5:0] enc6_m(input logic [4:0] x);
        case (x)
            5'd0:    enc6_m = 6'b100111;
            5'd1:    enc6_m = 6'b011101;
            5'd2:    enc6_m = 6'b101101;
            5'd3:    enc6_m = 6'b110001;
            5'd4:    enc6_m = 6'b110101;
            5'd5:    enc6_m = 6'b101001;
            5'd6:    enc6_m = 6'b011001;
            5'd7:    enc6_m = 6'b111000;
            5'd8:    enc6_m = 6'b111001;
            5'd9:    enc6_m = 6'b100101;
            5'd10:   enc6_m = 6'b010101;
            5'd11:   enc6_m = 6'b110100;
            5'd12:   enc6_m = 6'b001101;
            5'd13:   enc6_m = 6'b101100;
            5'd14:   enc6_m = 6'b011100;
            5'd15:   enc6_m = 6'b010111;
            5'd16:   enc6_m = 6'b011011;
            5'd17:   enc6_m = 6'b100011;
            5'd18:   enc6_m = 6'b010011;
            5'd19:   enc6_m = 6'b110010;
            5'd20:   enc6_m = 6'b001011;
            5'd21:   enc6_m = 6'b101010;
            5'd22:   enc6_m = 6'b011010;
            5'd23:   enc6_m = 6'b111010;
            5'd24:   enc6_m = 6'b110011;
            5'd25:   enc6_m = 6'b100110;
            5'd26:   enc6_m = 6'b010110;
            5'd27:   enc6_m = 6'b110110;
            5'd28:   enc6_m = 6'b001110;
            5'd29:   enc6_m = 6'b101110;
            5'd30:   enc6_m = 6'b011110;
            5'd31:   enc6_m = 6'b101011;
            default: enc6_m = 6'b000000;
        endcase
    endfunction

    // Data 3b/4b code (fghj) for RD- at the 4b sub-block; alt selects A7 over P7.
    function automatic logic [3:0] enc4_d(input logic [2:0] y, input logic alt);
        case (y)
            3'd0:    enc4_d = 4'b1011;
            3'd1:    enc4_d = 4'b1001;
            3'd2:    enc4_d = 4'b0101;
            3'd3:    enc4_d = 4'b1100;
            3'd4:    enc4_d = 4'b1101;
            3'd5:    enc4_d = 4'b1010;
            3'd6:    enc4_d = 4'b0110;
            3'd7:    enc4_d = alt ? 4'b0111 : 4'b1110;
            default: enc4_d = 4'b0000;
        endcase
    endfunction

    // Control 3b/4b code for RD- at the 4b sub-block; RD+ is always its complement.
    function automatic logic [3:0] enc4_k(input logic [2:0] y);
        case (y)
            3'd0:    enc4_k = 4'b1011;
            3'd1:    enc4_k = 4'b0110;
            3'd2:    enc4_k = 4'b1010;
            3'd3:    enc4_k = 4'b1100;
            3'd4:    enc4_k = 4'b1101;
            3'd5:    enc4_k = 4'b0101;
            3'd6:    enc4_k = 4'b1001;
            3'd7:    enc4_k = 4'b0111;
            default: enc4_k = 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] ones6(input logic [5:0] c);
        ones6 = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]}
              + {2'b00, c[3]} + {2'b00, c[4]} + {2'b00, c[5]};
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] c);
        ones4 = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} + {2'b00, c[3]};
    endfunction

    // One lane: returns {err, rd_after, abcdei, fghj}. An unbalanced sub-block
    // flips the disparity; the neutral D.7 and D.x.3 codes still swap with RD.
    function automatic logic [11:0] encode_lane(input logic [7:0] b, input logic k,
                                                input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic       legal_k;
        logic       illegal_k;
        logic       rd6;
        logic       alt;
        logic       rd_out;
        logic [5:0] c6_m;
        logic [5:0] c6;
        logic [3:0] c4_m;
        logic [3:0] c4;
        x         = b[4:0];
        y         = b[7:5];
        legal_k   = k && ((x == 5'd28) || ((y == 3'd7) &&
                    ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30))));
        illegal_k = k && !legal_k;
        c6_m      = (legal_k && (x == 5'd28)) ? 6'b001111 : enc6_m(x);
        c6        = (rd_in && ((ones6(c6_m) != 3'd3) || (x == 5'd7))) ? ~c6_m : c6_m;
        rd6       = rd_in ^ (ones6(c6_m) != 3'd3);
        alt       = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                    ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        if (legal_k) begin
            c4_m = enc4_k(y);
            c4   = rd6 ? ~c4_m : c4_m;
        end else begin
            c4_m = enc4_d(y, alt);
            c4   = (rd6 && ((ones4(c4_m) != 3'd2) || (y == 3'd3))) ? ~c4_m : c4_m;
        end
        rd_out = rd6 ^ (ones4(c4_m) != 3'd2);
        if (illegal_k && ERR_ZERO) begin
            encode_lane = {1'b1, rd_in, 10'd0};
        end else begin
            encode_lane = {illegal_k, rd_out, c6, c4};
        end
    endfunction

    logic [10*LANES-1:0] salidas_r;
    logic [LANES-1:0]    rd_r;
    logic [LANES-1:0]    err_r;
    logic                valido_r;
    logic [10*LANES-1:0] code_s;
    logic [LANES-1:0]    rd_next_s;
    logic [LANES-1:0]    err_next_s;
    logic                listo_s;
    logic                accept_s;

    assign listo_s  = !valido_r || rdy;
    assign accept_s = enb && listo_s;

    // Encode every lane from its own current running disparity.
    always_comb begin
        code_s     = '0;
        rd_next_s  = '0;
        err_next_s = '0;
        for (int l = 32'sd0; l < LANES; l++) begin
            {err_next_s[l], rd_next_s[l], code_s[CW*l +: CW]} =
                encode_lane(entradas[BW*l +: BW], K[l], rd_r[l]);
        end
    end

    // Output stage: load on accept, drop valid once drained, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            salidas_r <= '0;
            rd_r      <= '0;
            err_r     <= '0;
            valido_r  <= 1'b0;
        end else if (accept_s) begin
            salidas_r <= code_s;
            rd_r      <= rd_next_s;
            err_r     <= err_next_s;
            valido_r  <= 1'b1;
        end else if (listo_s) begin
            valido_r  <= 1'b0;
        end
    end

    assign listo   = listo_s;
    assign salidas = salidas_r;
    assign valido  = valido_r;
    assign rd      = rd_r;
    assign err_k   = err_r;

endmodule

// File: tb/tb_encoder_8b10b_lanes.sv
// Bench for encoder_8b10b_lanes. It runs directed table vectors, a stall
// sequence, a mid-stream reset and random traffic. Every step is checked
// against a model that uses the explicit RD-/RD+ code tables.
module tb_encoder_8b10b_lanes;

    localparam int LANES    = 2;
    localparam bit ERR_ZERO = 1'b0;
    localparam int DW       = 8 * LANES;
    localparam int CW       = 10 * LANES;

    logic             clk = 1'b0;
    logic             rst;
    logic             enb;
    logic [DW-1:0]    entradas;
    logic [LANES-1:0] K;
    logic             rdy;
    logic             listo;
    logic [CW-1:0]    salidas;
    logic             valido;
    logic [LANES-1:0] rd;
    logic [LANES-1:0] err_k;

    int n_vec = 0;
    int n_bad = 0;

    logic [CW-1:0]    m_sal;
    logic [LANES-1:0] m_rd;
    logic [LANES-1:0] m_err;
    logic             m_val;

    always #5 clk = ~clk;

    encoder_8b10b_lanes #(.LANES(LANES), .ERR_ZERO(ERR_ZERO)) dut (
        .clk(clk), .rst(rst), .enb(enb), .entradas(entradas), .K(K), .rdy(rdy),
        .listo(listo), .salidas(salidas), .valido(valido), .rd(rd), .err_k(err_k)
    );

    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                       4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                       4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] LEGAL_K [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                            8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    // Disparity after a sub-block: more ones -> RD+, fewer -> RD-, balanced keeps.
    function automatic logic next_rd(input logic cur, input int ones, input int half);
        if (ones > half) return 1'b1;
        if (ones < half) return 1'b0;
        return cur;
    endfunction

    // Reference encoder: returns {err, rd_after, 10-bit word}.
    function automatic logic [11:0] ref_enc(input logic [7:0] b, input logic k, input logic rd_in);
        int x;
        int y;
        logic legal;
        logic rdm;
        logic rdo;
        logic [5:0] c6;
        logic [3:0] c4;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        legal = k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        if (k && !legal && ERR_ZERO) return {1'b1, rd_in, 10'd0};
        if (legal && x == 28) c6 = rd_in ? 6'b110000 : 6'b001111;
        else                  c6 = rd_in ? T6P[x] : T6N[x];
        rdm = next_rd(rd_in, $countones(c6), 3);
        if (legal)
            c4 = rdm ? K4P[y] : K4N[y];
        else if (y == 7 && ((!rdm && (x == 17 || x == 18 || x == 20)) ||
                            ( rdm && (x == 11 || x == 13 || x == 14))))
            c4 = rdm ? 4'b1000 : 4'b0111;
        else
            c4 = rdm ? T4P[y] : T4N[y];
        rdo = next_rd(rdm, $countones(c4), 2);
        return {k && !legal, rdo, c6, c4};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sal = '0;
        m_rd  = '0;
        m_err = '0;
        m_val = 1'b0;
    endtask

    // One clock: drive at negedge, check listo, advance the model, check outputs after posedge.
    task automatic step(input logic e, input logic [DW-1:0] d, input logic [LANES-1:0] k,
                        input logic rdy_i);
        logic acc;
        logic [11:0] res;
        @(negedge clk);
        enb = e; entradas = d; K = k; rdy = rdy_i;
        #1;
        chk("listo", 80'(listo), 80'(!m_val || rdy_i));
        acc = e && (!m_val || rdy_i);
        if (acc) begin
            for (int l = 0; l < LANES; l++) begin
                res = ref_enc(d[8*l +: 8], k[l], m_rd[l]);
                m_sal[10*l +: 10] = res[9:0];
                m_rd[l]  = res[10];
                m_err[l] = res[11];
            end
            m_val = 1'b1;
        end else if (!m_val || rdy_i) begin
            m_val = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("salidas", 80'(salidas), 80'(m_sal));
        chk("rd",      80'(rd),      80'(m_rd));
        chk("err_k",   80'(err_k),   80'(m_err));
        chk("valido",  80'(valido),  80'(m_val));
    endtask

    typedef struct {
        logic             e;
        logic [DW-1:0]    d;
        logic [LANES-1:0] k;
        logic             r;
        logic [CW-1:0]    sal;
        logic [LANES-1:0] rdv;
        logic [LANES-1:0] err;
        logic             val;
    } vec_t;

    vec_t tv [11];

    initial begin
        logic [DW-1:0]    d;
        logic [LANES-1:0] k;
        int               mode;

        // {enb, {lane1,lane0} bytes, K, rdy, expected {lane1,lane0} codes, rd, err_k, valido}
        tv[0]  = '{1'b1, 16'h0003, 2'b00, 1'b1, {10'b1001110100, 10'b1100011011}, 2'b01, 2'b00, 1'b1};
        tv[1]  = '{1'b1, 16'h0003, 2'b00, 1'b1, {10'b1001110100, 10'b1100010100}, 2'b00, 2'b00, 1'b1};
        tv[2]  = '{1'b1, 16'h0003, 2'b00, 1'b1, {10'b1001110100, 10'b1100011011}, 2'b01, 2'b00, 1'b1};
        tv[3]  = '{1'b1, 16'h0003, 2'b00, 1'b1, {10'b1001110100, 10'b1100010100}, 2'b00, 2'b00, 1'b1};
        tv[4]  = '{1'b1, 16'h03BC, 2'b01, 1'b1, {10'b1100011011, 10'b0011111010}, 2'b11, 2'b00, 1'b1};
        tv[5]  = '{1'b1, 16'h03BC, 2'b01, 1'b1, {10'b1100010100, 10'b1100000101}, 2'b00, 2'b00, 1'b1};
        tv[6]  = '{1'b1, 16'hBC03, 2'b11, 1'b1, {10'b0011111010, 10'b1100011011}, 2'b11, 2'b01, 1'b1};
        tv[7]  = '{1'b0, 16'h0000, 2'b00, 1'b1, {10'b0011111010, 10'b1100011011}, 2'b11, 2'b01, 1'b0};
        tv[8]  = '{1'b1, 16'h0300, 2'b00, 1'b1, {10'b1100010100, 10'b0110001011}, 2'b01, 2'b00, 1'b1};
        tv[9]  = '{1'b1, 16'hF1EB, 2'b00, 1'b1, {10'b1000110111, 10'b1101001000}, 2'b10, 2'b00, 1'b1};
        tv[10] = '{1'b1, 16'h1CF7, 2'b11, 1'b1, {10'b1100001011, 10'b1110101000}, 2'b10, 2'b00, 1'b1};

        rst = 1'b1; enb = 1'b0; rdy = 1'b1; entradas = '0; K = '0;
        model_reset();
        #12;
        chk("rst_salidas", 80'(salidas), 80'(0));
        chk("rst_valido",  80'(valido),  80'(0));
        chk("rst_rd",      80'(rd),      80'(0));
        chk("rst_err_k",   80'(err_k),   80'(0));
        chk("rst_listo",   80'(listo),   80'(1));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(tv[i].e, tv[i].d, tv[i].k, tv[i].r);
            chk($sformatf("tv%0d_salidas", i), 80'(salidas), 80'(tv[i].sal));
            chk($sformatf("tv%0d_rd", i),      80'(rd),      80'(tv[i].rdv));
            chk($sformatf("tv%0d_err_k", i),   80'(err_k),   80'(tv[i].err));
            chk($sformatf("tv%0d_valido", i),  80'(valido),  80'(tv[i].val));
        end

        // Backpressure: three stalled cycles with new data offered, then release.
        step(1'b1, 16'h0300, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'hBCBC, 2'b11, 1'b0);
            chk("stall_listo", 80'(listo), 80'(0));
        end
        step(1'b1, 16'h0300, 2'b00, 1'b1);
        step(1'b1, 16'h0300, 2'b00, 1'b1);

        // Asynchronous reset mid-stream; no accept while it is held.
        rst = 1'b1; enb = 1'b1; entradas = 16'h0303; K = 2'b00;
        #2;
        model_reset();
        chk("mrst_salidas", 80'(salidas), 80'(0));
        chk("mrst_valido",  80'(valido),  80'(0));
        chk("mrst_rd",      80'(rd),      80'(0));
        chk("mrst_listo",   80'(listo),   80'(1));
        @(posedge clk);
        #1;
        chk("mrst_noacc", 80'(valido), 80'(0));
        @(negedge clk);
        rst = 1'b0; enb = 1'b0;
        step(1'b1, 16'h0303, 2'b00, 1'b1);
        chk("post_rst_d3", 80'(salidas), 80'({10'b1100011011, 10'b1100011011}));

        // Random traffic with mixed data, legal and illegal control requests.
        for (int n = 0; n < 600; n++) begin
            for (int l = 0; l < LANES; l++) begin
                mode = $urandom_range(0, 5);
                if (mode < 4) begin
                    d[8*l +: 8] = 8'($urandom);
                    k[l] = 1'b0;
                end else if (mode == 4) begin
                    d[8*l +: 8] = LEGAL_K[$urandom_range(0, 11)];
                    k[l] = 1'b1;
                end else begin
                    d[8*l +: 8] = 8'($urandom);
                    k[l] = 1'b1;
                end
            end
            step($urandom_range(0, 3) != 0, d, k, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
